alu_share_ctrl: RTL

- Arbitrates and sequences one shared 4-bit ALU (3-bit op select, 4-bit A/B, 8-bit result) between two requesters.
- Uses a valid/ready handshake on the request side and a round-robin grant.
- Drives the ALU operands for a programmable settle time, then captures the result and returns it to the winning requester as a one-cycle response pulse.
- Sits between client logic and the combinational ALU; the ALU is instantiated outside this block.

---
 rtl/alu_share_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl
// Shares one external combinational 4-bit ALU between two requesters.
// The winning request's op and operands are latched onto the ALU inputs and
// held for SETTLE_CYCLES cycles. The ALU result is then captured and returned
// to the owner as a one-cycle response pulse.
//
// Ports
//   clk, rst                     : clock (rising edge), synchronous active-high reset
//   reqN_valid / reqN_ready      : request handshake, N = 0, 1 (ready is combinational)
//   reqN_op / reqN_a / reqN_b    : 3-bit op select and 4-bit operands of requester N
//   alu_s / alu_a / alu_b        : registered drive to the external ALU
//   alu_out                      : 8-bit ALU result
//   rsp0_valid / rsp1_valid      : one-cycle pulse telling which requester owns rsp_data
//   rsp_data                     : captured ALU result, held until the next capture
//   busy                         : high whenever an operation is in flight
module alu_share_ctrl #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [2:0] req0_op,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [2:0] req1_op,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic [2:0] alu_s,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [7:0] alu_out,
    output logic       rsp0_valid,
    output logic       rsp1_valid,
    output logic [7:0] rsp_data,
    output logic       busy
);

    // A settle time of zero would capture before the operands were ever driven,
    // so it is promoted to one cycle.
    localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int CNT_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_EFF - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             owner;       // 0: requester 0, 1: requester 1
    logic             last_grant;  // reset to 1 so requester 0 wins the first tie
    logic             grant0;
    logic             grant1;
    logic             capture;

    // Round-robin: a lone requester always wins; on a tie the requester that
    // was not served last wins.
    assign grant0 = req0_valid & (~req1_valid | last_grant);
    assign grant1 = req1_valid & (~req0_valid | ~last_grant);

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                // grant0 and grant1 are mutually exclusive, so at most one ready.
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 | grant1) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt == CNT_LAST) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_s      <= 3'd0;
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            rsp_data   <= 8'd0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
        end else begin
            // Ready is only ever high in IDLE, so ready alone marks the handshake.
            if (req0_ready) begin
                alu_s      <= req0_op;
                alu_a      <= req0_a;
                alu_b      <= req0_b;
                owner      <= 1'b0;
                last_grant <= 1'b0;
                cnt        <= '0;
            end else if (req1_ready) begin
                alu_s      <= req1_op;
                alu_a      <= req1_a;
                alu_b      <= req1_b;
                owner      <= 1'b1;
                last_grant <= 1'b1;
                cnt        <= '0;
            end else if (state == ISSUE) begin
                cnt <= cnt + 1'b1;
            end

            if (capture) begin
                rsp_data <= alu_out;
            end
            // Capture only happens on the last ISSUE edge, so each pulse lands
            // in the single RESP cycle.
            rsp0_valid <= capture & ~owner;
            rsp1_valid <= capture & owner;
        end
    end

endmodule
